// File: rtl/routine_pkg.sv
// -----------------------------------------------------------------------------
// routine_pkg
//   Shared definitions for the light-routine sequencer. It holds the field
//   layout of the 47-bit routine bus, the blank segment pattern, the sequencer
//   state encoding and a small one-hot helper.
//   Bus layout: [46] done, [45:28] LEDs 17..0, [27:21] Disp3, [20:14] Disp2,
//               [13:7] Disp1, [6:0] Disp0.
// -----------------------------------------------------------------------------
package routine_pkg;

   localparam int ROUTINE_BUS_W = 47;
   localparam int NUM_ROUTINES  = 4;
   localparam int LED_W         = 18;
   localparam int HEX_W         = 7;

   localparam int DONE_BIT = 46;
   localparam int LED_HI   = 45;
   localparam int LED_LO   = 28;
   localparam int DISP3_HI = 27;
   localparam int DISP3_LO = 21;
   localparam int DISP2_HI = 20;
   localparam int DISP2_LO = 14;
   localparam int DISP1_HI = 13;
   localparam int DISP1_LO = 7;
   localparam int DISP0_HI = 6;
   localparam int DISP0_LO = 0;

   // Segments are active-low, so all ones turns every segment off.
   localparam logic [HEX_W-1:0] HEX_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      S_INIT   = 2'd0,
      S_RUN    = 2'd1,
      S_SWITCH = 2'd2
   } seq_state_e;

   // Per-routine reset pattern that restarts only the routine at idx.
   function automatic logic [NUM_ROUTINES-1:0] onehot_sel(input logic [1:0] idx);
      onehot_sel = 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Synchronises a raw asynchronous pushbutton. It accepts a new level only
//   after DEBOUNCE_LEN identical consecutive samples. On an accepted press it
//   emits a single-cycle pulse, so a held button gives one pulse, and it re-arms
//   once a release has been accepted.
//   Ports:
//     Clock  in  system clock
//     Reset  in  synchronous, active-low reset (clears to "released")
//     Raw    in  raw button level, asynchronous, active-high
//     Pulse  out one-cycle pulse on an accepted press
// -----------------------------------------------------------------------------
module button_debouncer
   import routine_pkg::*;
#(
   parameter int DEBOUNCE_LEN = 4
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Raw,
   output logic Pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_LEN + 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             pulse_q;
   logic [CNT_W-1:0] cnt_q;
   logic             accept_d;

   // The counter holds how many consecutive samples already disagreed with
   // the accepted level. This sample makes the count DEBOUNCE_LEN.
   assign accept_d = (sync2_q != level_q) && (cnt_q == CNT_W'(DEBOUNCE_LEN - 1));

   // NOTE: state is updated with non-blocking assignments so that every
   // register samples the values from before the clock edge, giving true flops.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= Raw;
         sync2_q <= sync1_q;
         pulse_q <= 1'b0;
         if (sync2_q == level_q) begin
            cnt_q <= '0;                 // any bounce back restarts the run
         end else if (accept_d) begin
            level_q <= sync2_q;
            cnt_q   <= '0;
            pulse_q <= sync2_q;          // only an accepted press produces a pulse
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign Pulse = pulse_q;

endmodule

// File: rtl/routine_sequencer.sv
// -----------------------------------------------------------------------------
// routine_sequencer
//   Consumer end of four 47-bit light-routine buses. It shows one selected
//   routine on 18 red LEDs and four seven-segment displays. It moves to the
//   next routine after LOOPS_PER_ROUTINE done pulses (AutoMode) or on a
//   debounced Advance press, and blanks the outputs while it switches. It also
//   restarts each routine through RoutineReset so the routine begins at its
//   first frame.
//   Ports:
//     Clock, Reset            system clock, synchronous active-low reset
//     RoutineBus0..3  in  47  routine buses (done, LEDs, Disp3..Disp0)
//     Advance         in   1  raw pushbutton, asynchronous, active-high
//     AutoMode        in   1  1 = advance after LOOPS_PER_ROUTINE passes
//     RoutineReset    out  4  per-routine restart, active-high
//     RoutineSel      out  2  index of the routine being shown
//     LedRed          out 18  registered LED field
//     Hex3..Hex0      out  7  registered display fields, active-low
// -----------------------------------------------------------------------------
module routine_sequencer
   import routine_pkg::*;
#(
   parameter int LOOPS_PER_ROUTINE = 2,
   parameter int DEBOUNCE_LEN      = 4,
   parameter int BLANK_CYCLES      = 3
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic [ROUTINE_BUS_W-1:0] RoutineBus0,
   input  logic [ROUTINE_BUS_W-1:0] RoutineBus1,
   input  logic [ROUTINE_BUS_W-1:0] RoutineBus2,
   input  logic [ROUTINE_BUS_W-1:0] RoutineBus3,
   input  logic                     Advance,
   input  logic                     AutoMode,
   output logic [NUM_ROUTINES-1:0]  RoutineReset,
   output logic [1:0]               RoutineSel,
   output logic [LED_W-1:0]         LedRed,
   output logic [HEX_W-1:0]         Hex3,
   output logic [HEX_W-1:0]         Hex2,
   output logic [HEX_W-1:0]         Hex1,
   output logic [HEX_W-1:0]         Hex0
);

   localparam int CNT_W = $clog2(LOOPS_PER_ROUTINE + 1);
   localparam int BLK_W = $clog2(BLANK_CYCLES + 1);

   seq_state_e                state_q;
   logic [1:0]                sel_q;
   logic [CNT_W-1:0]          loop_cnt_q;
   logic [CNT_W-1:0]          loop_cnt_d;
   logic [BLK_W-1:0]          blank_cnt_q;
   logic [NUM_ROUTINES-1:0]   rreset_q;
   logic [LED_W-1:0]          led_q;
   logic [3:0][HEX_W-1:0]     hex_q;
   logic [ROUTINE_BUS_W-1:0]  bus_sel;
   logic                      adv_pulse;
   logic                      switch_d;

   button_debouncer #(
      .DEBOUNCE_LEN (DEBOUNCE_LEN)
   ) u_debouncer (
      .Clock (Clock),
      .Reset (Reset),
      .Raw   (Advance),
      .Pulse (adv_pulse)
   );

   // NOTE: every variable written here gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      bus_sel = RoutineBus0;
      unique case (sel_q)
         2'd0: bus_sel = RoutineBus0;
         2'd1: bus_sel = RoutineBus1;
         2'd2: bus_sel = RoutineBus2;
         2'd3: bus_sel = RoutineBus3;
         default: bus_sel = RoutineBus0;
      endcase
   end

   // The loop count saturates at LOOPS_PER_ROUTINE. With AutoMode off it can
   // sit there, and raising AutoMode then switches on the next edge.
   always_comb begin
      loop_cnt_d = loop_cnt_q;
      if (bus_sel[DONE_BIT] && (loop_cnt_q != CNT_W'(LOOPS_PER_ROUTINE))) begin
         loop_cnt_d = loop_cnt_q + 1'b1;
      end
      switch_d = adv_pulse || (AutoMode && (loop_cnt_d >= CNT_W'(LOOPS_PER_ROUTINE)));
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q     <= S_INIT;
         sel_q       <= 2'd0;
         loop_cnt_q  <= '0;
         blank_cnt_q <= '0;
         rreset_q    <= '1;
         led_q       <= '0;
         hex_q       <= {4{HEX_BLANK}};
      end else begin
         unique case (state_q)
            S_INIT: begin
               state_q  <= S_RUN;
               rreset_q <= '0;
               led_q    <= '0;
               hex_q    <= {4{HEX_BLANK}};
            end
            S_RUN: begin
               if (switch_d) begin
                  state_q     <= S_SWITCH;
                  sel_q       <= sel_q + 2'd1;
                  rreset_q    <= onehot_sel(sel_q + 2'd1);
                  loop_cnt_q  <= '0;
                  blank_cnt_q <= BLK_W'(BLANK_CYCLES - 1);
                  led_q       <= '0;
                  hex_q       <= {4{HEX_BLANK}};
               end else begin
                  loop_cnt_q <= loop_cnt_d;
                  led_q      <= bus_sel[LED_HI:LED_LO];
                  hex_q      <= {bus_sel[DISP3_HI:DISP3_LO], bus_sel[DISP2_HI:DISP2_LO],
                                 bus_sel[DISP1_HI:DISP1_LO], bus_sel[DISP0_HI:DISP0_LO]};
               end
            end
            S_SWITCH: begin
               // The restart lasts one cycle. Done bits and presses seen here are dropped.
               rreset_q <= '0;
               if (blank_cnt_q == '0) begin
                  // Load the new routine on the last blank cycle, so the
                  // outputs stay blank for exactly BLANK_CYCLES cycles.
                  state_q <= S_RUN;
                  led_q   <= bus_sel[LED_HI:LED_LO];
                  hex_q   <= {bus_sel[DISP3_HI:DISP3_LO], bus_sel[DISP2_HI:DISP2_LO],
                              bus_sel[DISP1_HI:DISP1_LO], bus_sel[DISP0_HI:DISP0_LO]};
               end else begin
                  blank_cnt_q <= blank_cnt_q - 1'b1;
               end
            end
            default: begin
               state_q  <= S_INIT;
               rreset_q <= '1;
            end
         endcase
      end
   end

   assign RoutineReset = rreset_q;
   assign RoutineSel   = sel_q;
   assign LedRed       = led_q;
   assign Hex3         = hex_q[3];
   assign Hex2         = hex_q[2];
   assign Hex1         = hex_q[1];
   assign Hex0         = hex_q[0];

endmodule

// File: tb/tb_routine_sequencer.sv
// -----------------------------------------------------------------------------
// tb_routine_sequencer
//   Directed bench for routine_sequencer with default parameters
//   (LOOPS_PER_ROUTINE=2, DEBOUNCE_LEN=4, BLANK_CYCLES=3).
// -----------------------------------------------------------------------------
module tb_routine_sequencer;

   localparam int DLEN = 4;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [46:0] bus [4];
   logic        Advance;
   logic        AutoMode;
   logic [3:0]  RoutineReset;
   logic [1:0]  RoutineSel;
   logic [17:0] LedRed;
   logic [6:0]  Hex3, Hex2, Hex1, Hex0;

   int n_cmp = 0;
   int n_err = 0;

   routine_sequencer dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .RoutineBus0  (bus[0]),
      .RoutineBus1  (bus[1]),
      .RoutineBus2  (bus[2]),
      .RoutineBus3  (bus[3]),
      .Advance      (Advance),
      .AutoMode     (AutoMode),
      .RoutineReset (RoutineReset),
      .RoutineSel   (RoutineSel),
      .LedRed       (LedRed),
      .Hex3         (Hex3),
      .Hex2         (Hex2),
      .Hex1         (Hex1),
      .Hex0         (Hex0)
   );

   always #5 Clock = ~Clock;

   function automatic logic [46:0] make_bus(input logic done, input logic [17:0] led,
                                            input logic [6:0] d3, input logic [6:0] d2,
                                            input logic [6:0] d1, input logic [6:0] d0);
      make_bus = {done, led, d3, d2, d1, d0};
   endfunction

   // Move 1 time unit past the next rising edge. Inputs driven here are
   // sampled at the next edge, and outputs read here show the edge just passed.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge Clock);
         #1;
      end
   endtask

   task automatic set_default_buses();
      bus[0] = make_bus(1'b0, 18'h00F0F, 7'h01, 7'h02, 7'h03, 7'h04);
      bus[1] = make_bus(1'b0, 18'h1234A, 7'h11, 7'h12, 7'h13, 7'h14);
      bus[2] = make_bus(1'b0, 18'h0ABCD, 7'h21, 7'h22, 7'h23, 7'h24);
      bus[3] = make_bus(1'b0, 18'h3FFFF, 7'h31, 7'h32, 7'h33, 7'h34);
   endtask

   // Wait, with a bound, for RoutineSel to leave prev. Returns the number of ticks taken.
   task automatic wait_switch(input logic [1:0] prev, output int ticks);
      ticks = 0;
      while (RoutineSel === prev && ticks < 20) begin
         tick();
         ticks++;
      end
   endtask

   task automatic test_reset();
      Reset = 1'b0; Advance = 1'b0; AutoMode = 1'b0;
      set_default_buses();
      tick(2);
      n_cmp++; if (RoutineReset !== 4'b1111) begin n_err++; $display("FAIL reset_rr: got %b want 1111", RoutineReset); end
      n_cmp++; if (RoutineSel !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", RoutineSel); end
      n_cmp++; if (LedRed !== 18'h0) begin n_err++; $display("FAIL reset_led: got %h want 0", LedRed); end
      n_cmp++; if ({Hex3, Hex2, Hex1, Hex0} !== {4{7'h7F}}) begin n_err++; $display("FAIL reset_hex: got %h want all 7F", {Hex3, Hex2, Hex1, Hex0}); end
      Reset = 1'b1;
      tick();                                   // S_INIT -> S_RUN
      n_cmp++; if (RoutineReset !== 4'b0000) begin n_err++; $display("FAIL run_rr: got %b want 0000", RoutineReset); end
      n_cmp++; if (LedRed !== 18'h0 || Hex0 !== 7'h7F) begin n_err++; $display("FAIL first_run_blank: got led %h hex0 %h want 0/7F", LedRed, Hex0); end
      tick();
      n_cmp++; if (LedRed !== 18'h00F0F || Hex3 !== 7'h01 || Hex0 !== 7'h04) begin n_err++; $display("FAIL run_bus0: got led %h hex3 %h hex0 %h want 00f0f/01/04", LedRed, Hex3, Hex0); end
   endtask

   task automatic test_data_path();
      bus[0] = make_bus(1'b0, 18'h2AAAA, 7'h40, 7'h02, 7'h03, 7'h04);
      tick();
      n_cmp++; if (LedRed !== 18'h2AAAA || Hex3 !== 7'h40) begin n_err++; $display("FAIL data_aa: got led %h hex3 %h want 2aaaa/40", LedRed, Hex3); end
      bus[0] = make_bus(1'b0, 18'h15555, 7'h7E, 7'h5A, 7'h25, 7'h3F);
      tick();
      n_cmp++; if ({LedRed, Hex3, Hex2, Hex1, Hex0} !== {18'h15555, 7'h7E, 7'h5A, 7'h25, 7'h3F}) begin
         n_err++; $display("FAIL data_55: got %h want %h", {LedRed, Hex3, Hex2, Hex1, Hex0}, {18'h15555, 7'h7E, 7'h5A, 7'h25, 7'h3F});
      end
      set_default_buses();
      tick();
   endtask

   task automatic test_ignore_other_done();
      AutoMode = 1'b1;
      bus[1][46] = 1'b1; bus[2][46] = 1'b1; bus[3][46] = 1'b1;
      tick(3);
      bus[1][46] = 1'b0; bus[2][46] = 1'b0; bus[3][46] = 1'b0;
      tick();
      n_cmp++; if (RoutineSel !== 2'd0) begin n_err++; $display("FAIL ignore_other_done: got sel %0d want 0", RoutineSel); end
   endtask

   task automatic test_auto_advance();
      bus[0][46] = 1'b1; tick();
      bus[0][46] = 1'b0; tick();
      n_cmp++; if (RoutineSel !== 2'd0) begin n_err++; $display("FAIL auto_one_pass: got sel %0d want 0", RoutineSel); end
      bus[0][46] = 1'b1; tick();                // second pass -> switch
      bus[0][46] = 1'b0;
      n_cmp++; if (RoutineSel !== 2'd1 || RoutineReset !== 4'b0010) begin n_err++; $display("FAIL auto_switch: got sel %0d rr %b want 1/0010", RoutineSel, RoutineReset); end
      n_cmp++; if (LedRed !== 18'h0 || Hex2 !== 7'h7F) begin n_err++; $display("FAIL auto_blank1: got led %h hex2 %h want 0/7F", LedRed, Hex2); end
      tick();
      n_cmp++; if (RoutineReset !== 4'b0000 || LedRed !== 18'h0) begin n_err++; $display("FAIL auto_blank2: got rr %b led %h want 0000/0", RoutineReset, LedRed); end
      tick();
      n_cmp++; if (LedRed !== 18'h0 || Hex1 !== 7'h7F) begin n_err++; $display("FAIL auto_blank3: got led %h hex1 %h want 0/7F", LedRed, Hex1); end
      tick();
      n_cmp++; if (LedRed !== 18'h1234A || Hex3 !== 7'h11 || Hex0 !== 7'h14) begin n_err++; $display("FAIL auto_bus1: got led %h hex3 %h hex0 %h want 1234a/11/14", LedRed, Hex3, Hex0); end
   endtask

   task automatic test_debounce();
      int t;
      AutoMode = 1'b0;
      Advance = 1'b1; tick();
      Advance = 1'b0; tick();
      Advance = 1'b1; tick();
      Advance = 1'b0; tick();
      n_cmp++; if (RoutineSel !== 2'd1) begin n_err++; $display("FAIL bounce_no_switch: got sel %0d want 1", RoutineSel); end
      Advance = 1'b1;                           // stable high begins
      wait_switch(2'd1, t);
      n_cmp++; if (RoutineSel !== 2'd2 || t < DLEN + 2 || t > DLEN + 3) begin
         n_err++; $display("FAIL debounce_latency: got sel %0d after %0d cycles want 2 after %0d..%0d", RoutineSel, t, DLEN + 2, DLEN + 3);
      end
      tick(12 - t);                             // keep holding the button
      n_cmp++; if (RoutineSel !== 2'd2) begin n_err++; $display("FAIL held_one_pulse: got sel %0d want 2", RoutineSel); end
      Advance = 1'b0;
      tick(8);
      n_cmp++; if (RoutineSel !== 2'd2) begin n_err++; $display("FAIL release_no_pulse: got sel %0d want 2", RoutineSel); end
   endtask

   task automatic test_done_and_advance();
      int t;
      AutoMode = 1'b1;
      bus[2][46] = 1'b1; tick();                // count = 1
      bus[2][46] = 1'b0;
      Advance = 1'b1;
      tick(DLEN + 2);                           // pulse now visible to the FSM
      bus[2][46] = 1'b1; tick();                // done and pulse on the same edge
      bus[2][46] = 1'b0;
      n_cmp++; if (RoutineSel !== 2'd3 || RoutineReset !== 4'b1000) begin n_err++; $display("FAIL same_cycle_switch: got sel %0d rr %b want 3/1000", RoutineSel, RoutineReset); end
      tick(3);
      n_cmp++; if (RoutineSel !== 2'd3 || LedRed !== 18'h3FFFF) begin n_err++; $display("FAIL single_switch: got sel %0d led %h want 3/3ffff", RoutineSel, LedRed); end
      bus[3][46] = 1'b1; tick();                // one pass on the new routine
      bus[3][46] = 1'b0; tick(2);
      n_cmp++; if (RoutineSel !== 2'd3) begin n_err++; $display("FAIL count_cleared: got sel %0d want 3", RoutineSel); end
      Advance = 1'b0; AutoMode = 1'b0;
      tick(8);
      Advance = 1'b1;
      wait_switch(2'd3, t);
      n_cmp++; if (RoutineSel !== 2'd0 || RoutineReset !== 4'b0001) begin n_err++; $display("FAIL wrap_switch: got sel %0d rr %b want 0/0001", RoutineSel, RoutineReset); end
      Advance = 1'b0;
      tick(8);
   endtask

   task automatic test_auto_toggle();
      bus[0][46] = 1'b1; tick(5);               // five passes with AutoMode off
      bus[0][46] = 1'b0; tick(2);
      n_cmp++; if (RoutineSel !== 2'd0) begin n_err++; $display("FAIL manual_no_auto: got sel %0d want 0", RoutineSel); end
      AutoMode = 1'b1; tick();                  // saturated count switches now
      n_cmp++; if (RoutineSel !== 2'd1 || RoutineReset !== 4'b0010) begin n_err++; $display("FAIL auto_toggle_switch: got sel %0d rr %b want 1/0010", RoutineSel, RoutineReset); end
      AutoMode = 1'b0;
      tick(4);
   endtask

   task automatic test_reset_mid_switch();
      int t;
      Advance = 1'b1;
      wait_switch(2'd1, t);                     // first blank cycle
      n_cmp++; if (RoutineSel !== 2'd2 || LedRed !== 18'h0) begin n_err++; $display("FAIL pre_reset_switch: got sel %0d led %h want 2/0", RoutineSel, LedRed); end
      tick();                                   // second blank cycle
      Reset = 1'b0; Advance = 1'b0;
      tick();
      n_cmp++; if (RoutineSel !== 2'd0 || RoutineReset !== 4'b1111) begin n_err++; $display("FAIL mid_reset_sel: got sel %0d rr %b want 0/1111", RoutineSel, RoutineReset); end
      n_cmp++; if (LedRed !== 18'h0 || {Hex3, Hex2, Hex1, Hex0} !== {4{7'h7F}}) begin n_err++; $display("FAIL mid_reset_out: got led %h hex %h want 0/all 7F", LedRed, {Hex3, Hex2, Hex1, Hex0}); end
      Reset = 1'b1;
      tick();
      n_cmp++; if (RoutineReset !== 4'b0000) begin n_err++; $display("FAIL mid_reset_init: got rr %b want 0000", RoutineReset); end
      tick();
      n_cmp++; if (LedRed !== 18'h00F0F || RoutineSel !== 2'd0) begin n_err++; $display("FAIL mid_reset_resume: got led %h sel %0d want 00f0f/0", LedRed, RoutineSel); end
   endtask

   initial begin
      test_reset();
      test_data_path();
      test_ignore_other_done();
      test_auto_advance();
      test_debounce();
      test_done_and_advance();
      test_auto_toggle();
      test_reset_mid_switch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
